// File: rtl/ps2_keyboard_rx_if.sv
// Keyboard-side bundle: raw PS/2 lines in, key status word and event pulses out.
interface ps2_keyboard_rx_if #(
  parameter int bus = 32
);
  logic           ps2_clk;
  logic           ps2_data;
  logic [bus-1:0] keyword;
  logic           key_valid;
  logic           frame_err;

  // Receiver side: samples the PS/2 lines, produces the key status word.
  modport master (
    input  ps2_clk,
    input  ps2_data,
    output keyword,
    output key_valid,
    output frame_err
  );

  // Line driver / word consumer side.
  modport slave (
    output ps2_clk,
    output ps2_data,
    input  keyword,
    input  key_valid,
    input  frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: syncs and filters the keyboard lines, checks each
// 11-bit frame, folds E0/F0 prefixes into the next key code and publishes
// the result as one 32-bit status word with an event counter in [23:16].
module ps2_keyboard_rx #(
  parameter int bus     = 32,
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 10000
) (
  input logic              clk,
  input logic              rst_n,
  ps2_keyboard_rx_if.master bus_if
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            r_state, w_state_nx;
  logic [1:0]        r_clk_s, r_dat_s;
  logic [FILTER-1:0] r_filt;
  logic              r_clk_f;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_byte;
  logic              r_par;
  logic [CW-1:0]     r_idle_cnt;
  logic              r_ext_pend, r_brk_pend;
  logic [bus-1:0]    r_keyword;
  logic              r_key_valid, r_frame_err;

  logic w_fall, w_data, w_timeout, w_done, w_abort, w_good;

  // A filtered falling edge is the cycle the level is about to drop to 0.
  assign w_fall    = r_clk_f & ~|r_filt;
  assign w_data    = r_dat_s[1];
  assign w_timeout = (r_idle_cnt == CW'(TIMEOUT - 1));
  // Odd ones count over data+parity, and the stop bit sampled now must be 1.
  assign w_good    = (^{r_byte, r_par}) & w_data;

  // Two-flop synchronizers and the clock glitch filter; idle level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_filt  <= '1;
      r_clk_f <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // sees the pre-edge value of its neighbours, exactly like hardware.
      r_clk_s <= {r_clk_s[0], bus_if.ps2_clk};
      r_dat_s <= {r_dat_s[0], bus_if.ps2_data};
      r_filt  <= {r_filt[FILTER-2:0], r_clk_s[1]};
      if (&r_filt)
        r_clk_f <= 1'b1;
      else if (~|r_filt)
        r_clk_f <= 1'b0;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nx;
  end

  // Next state plus frame-complete / frame-abort strobes; an edge beats a timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    w_state_nx = r_state;
    w_done     = 1'b0;
    w_abort    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall && !w_data) w_state_nx = S_DATA;
      end
      S_DATA: begin
        if (w_fall) begin
          if (r_bit_cnt == 3'd7) w_state_nx = S_PARITY;
        end else if (w_timeout) begin
          w_state_nx = S_IDLE;
          w_abort    = 1'b1;
        end
      end
      S_PARITY: begin
        if (w_fall) begin
          w_state_nx = S_STOP;
        end else if (w_timeout) begin
          w_state_nx = S_IDLE;
          w_abort    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_fall) begin
          w_state_nx = S_IDLE;
          w_done     = 1'b1;
        end else if (w_timeout) begin
          w_state_nx = S_IDLE;
          w_abort    = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Bit assembly, inter-edge idle counter, prefix flags and the status word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_byte      <= '0;
      r_par       <= 1'b0;
      r_idle_cnt  <= '0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
      r_keyword   <= '0;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;

      if (r_state == S_IDLE || w_fall)
        r_idle_cnt <= '0;
      else
        r_idle_cnt <= r_idle_cnt + 1'b1;

      if (r_state == S_IDLE && w_fall && !w_data)
        r_bit_cnt <= '0;

      // LSB arrives first, so shift in from the top.
      if (r_state == S_DATA && w_fall) begin
        r_byte    <= {w_data, r_byte[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      if (r_state == S_PARITY && w_fall)
        r_par <= w_data;

      if (w_done && w_good) begin
        if (r_byte == 8'hE0) begin
          r_ext_pend <= 1'b1;
        end else if (r_byte == 8'hF0) begin
          r_brk_pend <= 1'b1;
        end else begin
          r_keyword[7:0]   <= r_byte;
          r_keyword[8]     <= r_brk_pend;
          r_keyword[9]     <= r_ext_pend;
          r_keyword[23:16] <= r_keyword[23:16] + 8'd1;
          r_keyword[31]    <= 1'b0;
          r_key_valid      <= 1'b1;
          r_ext_pend       <= 1'b0;
          r_brk_pend       <= 1'b0;
        end
      end else if ((w_done && !w_good) || w_abort) begin
        r_keyword[31] <= 1'b1;
        r_frame_err   <= 1'b1;
        r_ext_pend    <= 1'b0;
        r_brk_pend    <= 1'b0;
      end
    end
  end

  assign bus_if.keyword   = r_keyword;
  assign bus_if.key_valid = r_key_valid;
  assign bus_if.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Directed bench for ps2_keyboard_rx: bit-bangs PS/2 frames and checks the
// status word and event pulses against hand-computed values.
module tb_ps2_keyboard_rx;

  localparam int FILTER  = 4;
  localparam int TIMEOUT = 200;
  localparam int HALF    = 8;   // PS/2 clock half period in clk cycles
  localparam int GAP     = 20;  // idle cycles after each frame

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_both   = 0;
  int v0, e0;

  ps2_keyboard_rx_if #(.bus(32)) u_if ();

  ps2_keyboard_rx #(
    .bus    (32),
    .FILTER (FILTER),
    .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_if(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (u_if.key_valid) n_valid++;
    if (u_if.frame_err) n_err++;
    if (u_if.key_valid && u_if.frame_err) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    u_if.ps2_data = b;
    repeat (HALF) @(posedge clk);
    u_if.ps2_clk = 1'b0;
    repeat (HALF) @(posedge clk);
    u_if.ps2_clk = 1'b1;
  endtask

  // Full frame: start, 8 data LSB first, odd parity (optionally inverted), stop.
  task automatic send_frame(input logic [7:0] b, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ par_flip);
    send_bit(1'b1);
    u_if.ps2_data = 1'b1;
    repeat (GAP) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    u_if.ps2_clk  = 1'b1;
    u_if.ps2_data = 1'b1;

    // Reset held while the lines toggle.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      u_if.ps2_clk  = i[1];
      u_if.ps2_data = i[2];
    end
    u_if.ps2_clk  = 1'b1;
    u_if.ps2_data = 1'b1;
    @(negedge clk);
    check("reset_keyword", u_if.keyword, 32'h0000_0000);
    check("reset_valid_cnt", n_valid, 0);
    check("reset_err_cnt", n_err, 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // First key event.
    v0 = n_valid;
    send_frame(8'h1C, 1'b0);
    check("first_1c", u_if.keyword, 32'h0001_001C);
    check("first_1c_pulses", n_valid - v0, 1);

    // E0 F0 74: prefixes alone change nothing, then one event.
    v0 = n_valid;
    send_frame(8'hE0, 1'b0);
    check("e0_no_change", u_if.keyword, 32'h0001_001C);
    send_frame(8'hF0, 1'b0);
    check("f0_no_change", u_if.keyword, 32'h0001_001C);
    send_frame(8'h74, 1'b0);
    check("e0f074_word", u_if.keyword, 32'h0002_0374);
    check("e0f074_pulses", n_valid - v0, 1);
    send_frame(8'h74, 1'b0);
    check("plain_74", u_if.keyword, 32'h0003_0074);

    // Parity error, then recovery.
    do_reset();
    send_frame(8'h1C, 1'b0);
    e0 = n_err;
    v0 = n_valid;
    send_frame(8'h1C, 1'b1);
    check("parity_err_word", u_if.keyword, 32'h8001_001C);
    check("parity_err_pulse", n_err - e0, 1);
    check("parity_err_no_valid", n_valid - v0, 0);
    send_frame(8'h29, 1'b0);
    check("after_err_29", u_if.keyword, 32'h0002_0029);

    // E0 pending, then a frame stalls after 4 data bits and times out.
    send_frame(8'hE0, 1'b0);
    e0 = n_err;
    send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    u_if.ps2_data = 1'b1;
    repeat (TIMEOUT + 10) @(posedge clk);
    @(negedge clk);
    check("timeout_pulse", n_err - e0, 1);
    check("timeout_word", u_if.keyword, 32'h8002_0029);
    send_frame(8'h1C, 1'b0);
    check("after_timeout_1c", u_if.keyword, 32'h0003_001C);

    // F0 pending, reset mid-frame clears everything.
    send_frame(8'hF0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst_n = 1'b0;
    u_if.ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("midreset_word", u_if.keyword, 32'h0000_0000);
    check("midreset_valid", {31'd0, u_if.key_valid}, 32'd0);
    check("midreset_err", {31'd0, u_if.frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    send_frame(8'h74, 1'b0);
    check("after_midreset_74", u_if.keyword, 32'h0001_0074);

    // Short low glitch on ps2_clk with data low must not start a frame.
    e0 = n_err;
    u_if.ps2_data = 1'b0;
    @(posedge clk);
    u_if.ps2_clk = 1'b0;
    repeat (FILTER - 1) @(posedge clk);
    u_if.ps2_clk = 1'b1;
    repeat (20) @(posedge clk);
    u_if.ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    send_frame(8'h29, 1'b0);
    check("glitch_then_29", u_if.keyword, 32'h0002_0029);
    check("glitch_no_err", n_err - e0, 0);

    // Event counter wraps after 256 events.
    do_reset();
    v0 = n_valid;
    for (int i = 0; i < 255; i++) send_frame(8'h1C, 1'b0);
    check("count_255", u_if.keyword, 32'h00FF_001C);
    send_frame(8'h1C, 1'b0);
    check("count_wrap", u_if.keyword, 32'h0000_001C);
    check("wrap_pulses", n_valid - v0, 256);

    check("never_both_pulses", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives PS/2 keyboard frames on the system clock and assembles each complete key event into one 32-bit status word. The word drives the data memory's keyboard input, which is mirrored into memory word 1, so software polls a single address for key activity. The block is the producer end of that keyboard word. It handles input synchronization, clock filtering, frame checking, E0/F0 prefix decoding and a timeout.

## Interface
- `bus`, default 32: width of `keyword`; must be ≥ 32.
- `FILTER`, default 8: consecutive equal samples required before the filtered `ps2_clk` level changes.
- `TIMEOUT`, default 10000: maximum clk cycles between filtered falling edges inside a frame.
- `clk` in 1: system clock; sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ps2_clk` in 1: keyboard clock, asynchronous, idle high.
- `ps2_data` in 1: keyboard data, asynchronous, idle high.
- `keyword` out bus: key status word, feeds the memory keyboard input.
- `key_valid` out 1: one-cycle pulse when `keyword` takes a new event.
- `frame_err` out 1: one-cycle pulse on a rejected frame.

## Operation
- Synchronization: `ps2_clk` and `ps2_data` each pass through 2 flops.
- Filtering: an `FILTER`-bit shift register samples the synced `ps2_clk`.
  - All ones sets the filtered level to 1; all zeros sets it to 0; otherwise the level holds.
  - A filtered 1→0 transition is a falling edge. Synced `ps2_data` is sampled on that cycle.
- Frame format: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: edge with data=0 → DATA, bit count = 0. Edge with data=1 → stay IDLE, no error.
  - DATA: shift the bit into the byte register. After the 8th bit → PARITY.
  - PARITY: latch the parity bit → STOP.
  - STOP: on the edge, check the frame, then → IDLE.
- Frame check: good only if data bits plus parity contain an odd number of ones **and** the stop bit is 1.
- Good frame, byte 0xE0: set `ext_pend`. No output change.
- Good frame, byte 0xF0: set `brk_pend`. No output change.
- Good frame, any other byte:
  - `keyword[7:0]` = byte, `[8]` = `brk_pend`, `[9]` = `ext_pend`.
  - `[23:16]` = `[23:16]` + 1, wrapping mod 256; `[31]` = 0.
  - Pulse `key_valid`; clear both pending flags.
- Bad frame:
  - Pulse `frame_err`; set `keyword[31]`; clear both pending flags.
  - `keyword[23:0]` unchanged.
- Timeout: in DATA, PARITY or STOP, an idle counter counts cycles since the last filtered falling edge.
  - Reaching `TIMEOUT` → IDLE, same effect as a bad frame.
  - The counter resets on every edge and in IDLE.
- `keyword[15:10]`, `[30:24]` and `[bus-1:32]` are always 0.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - FSM IDLE; filter register and filtered level all ones; sync flops all ones.
  - `keyword` = 0, `key_valid` = 0, `frame_err` = 0.
  - Pending flags, bit count and idle counter cleared.
  - Reset mid-frame discards the partial frame; the next frame must start from a fresh start bit.
- Edge detection latency: 2 sync cycles + `FILTER` cycles after the raw `ps2_clk` fall.
- `keyword` and the `key_valid`/`frame_err` pulses are registered. All three update in the cycle after the stop-bit edge is detected.
- `keyword` holds between events; it is never cleared except by reset.
- Timeout and the stop-bit edge can coincide; the edge takes priority and the frame is checked normally.
- `key_valid` and `frame_err` are never both 1.

## Test plan
- Reset: hold `rst_n`=0 with lines toggling → `keyword`=0x00000000, no pulses. Release, then send 0x1C (parity 0) → `keyword`=0x0001001C, one `key_valid` pulse.
- Prefixes: send E0, F0, 74 (parity 1) after the 0x1C event → exactly one `key_valid`, `keyword`=0x00020374. Then send 74 → `keyword`=0x00030074.
- Parity error: send 0x1C with parity 1 → `frame_err` pulse, `keyword`=0x8001001C. A following good 0x29 → `keyword`=0x00020029.
- Timeout and reset mid-frame:
  - Stop `ps2_clk` after 4 data bits for `TIMEOUT`+10 cycles → `frame_err`, FSM IDLE. A next full frame 0x1C decodes correctly.
  - Assert `rst_n` mid-frame → outputs 0; the next full frame decodes correctly.
- Glitch and wrap:
  - A `ps2_clk` low pulse shorter than `FILTER` cycles → no bit consumed.
  - 256 good 0x1C events → counter wraps to 0x00, `keyword`=0x0000001C.
